dom_mult_sched: RTL and testbench
=================================

Name: dom_mult_sched

Overview:
- Round-robin scheduler sharing one registered DOM-independent GF(2^2) masked multiplier among NREQ requesters.
- Arbitrates the requesters and gates issue on fresh randomness Z.
- Runs a 2-stage pipeline that carries requester IDs.
- Returns 2-share products with valid/ready backpressure.
- Used inside the masked S-box inversion path of the SSAES core.

Parameters:
NREQ, 4, number of requesters (2..8)
ID_W, 2, requester ID width, equal to clog2(NREQ)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  NREQ  per-requester operand valid
req_ready  out  NREQ  per-requester accept; at most one bit high per cycle
req_ax  in  2*NREQ  share A of operand x; requester i at bits [2i+1:2i]
req_ay  in  2*NREQ  share A of operand y, same packing
req_bx  in  2*NREQ  share B of operand x, same packing
req_by  in  2*NREQ  share B of operand y, same packing
rnd_valid  in  1  fresh 2-bit randomness available
rnd_z  in  2  fresh randomness Z
rnd_ready  out  1  Z consumed this cycle
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_id  out  ID_W  requester that issued the result
out_aq  out  2  result share A
out_bq  out  2  result share B
flush  in  1  drain request
flush_done  out  1  one-cycle pulse when drain completes
busy  out  1  pipeline holds at least one valid entry

Behaviour:
- Reset: all outputs 0, RR pointer 0, FSM in RUN, both pipeline stage valid bits 0.
- Arithmetic: all products use the existing GF22Mult (2-bit GF(2^2)).
- Issue (cycle t): grant the highest-priority valid requester when all of these hold:
  - FSM is RUN,
  - rnd_valid=1,
  - stage 1 is free or advancing.
- Priority search starts at the RR pointer and wraps at NREQ-1 to 0.
- On a grant g:
  - req_ready[g]=1 and rnd_ready=1 in the same cycle.
  - RR pointer becomes g+1 mod NREQ.
- No grant means req_ready=0 and rnd_ready=0; randomness is never consumed without an issue.
- Stage 1 registers, all loaded at issue:
  - Axy = Ax*Ay and Bxy = Bx*By (inner-domain products),
  - AxBy^Z and AyBx^Z (cross-domain terms refreshed with Z),
  - the granted ID.
- Cross-domain terms are never combined with inner-domain terms before this register.
- Stage 2 / output registers:
  - out_aq = Axy ^ (AxBy^Z)
  - out_bq = Bxy ^ (AyBx^Z)
  - out_id = ID carried from stage 1
- Latency: out_valid asserts at t+2 when out_ready has stayed high.
- Throughput: 1 op/cycle.
- Backpressure:
  - out_valid && !out_ready holds stage 2 stable.
  - Stage 1 advances only into an empty or draining stage 2; otherwise it stalls.
  - While stage 1 is stalled, no new grant is made.
  - Output values stay stable while out_valid=1 and out_ready=0.
- FSM:
  - RUN -> DRAIN when flush=1; no grant in that cycle or after.
  - DRAIN -> RUN when both stage valid bits are 0; flush_done=1 on that cycle only.
  - flush held high keeps the FSM in RUN after each completed drain, with no grants, until flush deasserts.
  - flush in DRAIN is ignored.
- busy = stage1_valid | stage2_valid.
- Edge cases:
  - rnd_valid=0 with requests pending: stall, and hold the RR pointer.
  - A single requester may win every cycle when it is the only one valid.
  - rst mid-operation discards all in-flight results; no out_valid follows.
  - NREQ that is not a power of two: the pointer wraps from NREQ-1 to 0 and never holds an out-of-range value.

Optional Feature:
- Macro: DOMSCHED_STATS_EN.
- When defined, add these outputs, all 0 on rst and saturating at all-ones:
  - stat_issued (16 bits): increments per grant.
  - stat_rnd_stall (16 bits): increments each cycle any req_valid=1 but rnd_valid=0 in RUN.
  - stat_bp_stall (16 bits): increments each cycle out_valid=1 and out_ready=0.
- When not defined, these ports and counters do not exist and the remaining behaviour is unchanged.

Test Plan:
- rst, then req_valid=0001 with Ax=2, Ay=3, Bx=0, By=0, rnd_z=0, rnd_valid=1, out_ready=1:
  - req_ready=0001 and rnd_ready=1 at t.
  - out_valid at t+2 with out_id=0, out_aq=GF22Mult(2,3), out_bq=0.
- Random shares and random Z on all 4 requesters, 1000 ops:
  - For every result, out_aq^out_bq == GF22Mult(Ax^Bx, Ay^By).
  - Result order equals grant order.
- req_valid=1111 held for 8 cycles:
  - Grants run 0,1,2,3,0,1,2,3.
  - Drop req_valid[1] in the 5th cycle: the next grants are 0,2,3.
- rnd_valid toggles 1,0,1 while requests stay valid:
  - No grant and rnd_ready=0 in the 0 cycle; the RR pointer is unchanged.
- out_ready=0 for 5 cycles with two ops in flight:
  - No further grants.
  - out_aq, out_bq and out_id stay stable.
  - After release both results emerge in consecutive cycles.
- flush pulsed with 2 ops in flight:
  - No grants until drained.
  - Two out_valid beats, then flush_done pulses once, and busy=0 on the same cycle.
  - Assert rst mid-drain: all outputs are 0 on the next cycle.

Source files
------------

// File: rtl/dom_mult_sched.sv
// dom_mult_sched: round-robin scheduler sharing one registered DOM GF(2^2) multiplier; `DOMSCHED_STATS_EN adds stall/issue counters.
module dom_mult_sched #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [2*NREQ-1:0] req_ax,
  input  logic [2*NREQ-1:0] req_ay,
  input  logic [2*NREQ-1:0] req_bx,
  input  logic [2*NREQ-1:0] req_by,
  input  logic              rnd_valid,
  input  logic [1:0]        rnd_z,
  output logic              rnd_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ID_W-1:0]   out_id,
  output logic [1:0]        out_aq,
  output logic [1:0]        out_bq,
  input  logic              flush,
  output logic              flush_done,
  output logic              busy
`ifdef DOMSCHED_STATS_EN
  ,
  output logic [15:0]       stat_issued,
  output logic [15:0]       stat_rnd_stall,
  output logic [15:0]       stat_bp_stall
`endif
);
  typedef enum logic {RUN, DRAIN} state_t;
  function automatic logic [1:0] gf22_mul(input logic [1:0] a, input logic [1:0] b);
    return {a[1] & b[1] ^ a[1] & b[0] ^ a[0] & b[1], a[1] & b[1] ^ a[0] & b[0]};
  endfunction
  state_t state_q, state_d;
  logic hold_q, hold_d;
  logic [ID_W-1:0] ptr_q, ptr_d, gnt_id, s1_id_q, s1_id_d, id_q, id_d;
  logic s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic [1:0] axy_q, axy_d, bxy_q, bxy_d, cab_q, cab_d, cba_q, cba_d;
  logic [1:0] aq_q, aq_d, bq_q, bq_d, ax, ay, bx, by;
  logic gnt_found, s2_free, s1_free, issue;
  always_comb begin
    gnt_found = 1'b0;
    gnt_id = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[ID_W'((int'(ptr_q) + k) % NREQ)]) begin
        gnt_found = 1'b1;
        gnt_id = ID_W'((int'(ptr_q) + k) % NREQ);
      end
    end
  end
  assign ax = req_ax[{gnt_id, 1'b0} +: 2];
  assign ay = req_ay[{gnt_id, 1'b0} +: 2];
  assign bx = req_bx[{gnt_id, 1'b0} +: 2];
  assign by = req_by[{gnt_id, 1'b0} +: 2];
  assign s2_free = !s2_v_q || out_ready;
  assign s1_free = !s1_v_q || s2_free;
  assign issue = !rst && state_q == RUN && !flush && rnd_valid && s1_free && gnt_found;
  assign flush_done = state_q == DRAIN && !s1_v_q && !s2_v_q;
  always_comb begin
    state_d = state_q == RUN ? ((flush && !hold_q) ? DRAIN : RUN) : (flush_done ? RUN : DRAIN);
    hold_d = flush && (flush_done || hold_q);
    ptr_d = issue ? ((int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + ID_W'(1)) : ptr_q;
    // Cross-domain terms are refreshed with Z and kept apart from inner products until stage 2.
    s1_v_d = issue || (s1_v_q && !s2_free);
    axy_d = issue ? gf22_mul(ax, ay) : axy_q;
    bxy_d = issue ? gf22_mul(bx, by) : bxy_q;
    cab_d = issue ? gf22_mul(ax, by) ^ rnd_z : cab_q;
    cba_d = issue ? gf22_mul(ay, bx) ^ rnd_z : cba_q;
    s1_id_d = issue ? gnt_id : s1_id_q;
    s2_v_d = s2_free ? s1_v_q : s2_v_q;
    aq_d = (s2_free && s1_v_q) ? axy_q ^ cab_q : aq_q;
    bq_d = (s2_free && s1_v_q) ? bxy_q ^ cba_q : bq_q;
    id_d = (s2_free && s1_v_q) ? s1_id_q : id_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      hold_q <= 1'b0;
      ptr_q <= '0;
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      axy_q <= '0;
      bxy_q <= '0;
      cab_q <= '0;
      cba_q <= '0;
      s1_id_q <= '0;
      aq_q <= '0;
      bq_q <= '0;
      id_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      ptr_q <= ptr_d;
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      axy_q <= axy_d;
      bxy_q <= bxy_d;
      cab_q <= cab_d;
      cba_q <= cba_d;
      s1_id_q <= s1_id_d;
      aq_q <= aq_d;
      bq_q <= bq_d;
      id_q <= id_d;
    end
  end
  assign req_ready = issue ? NREQ'(1) << gnt_id : '0;
  assign rnd_ready = issue;
  assign out_valid = s2_v_q;
  assign out_aq = aq_q;
  assign out_bq = bq_q;
  assign out_id = id_q;
  assign busy = s1_v_q || s2_v_q;
`ifdef DOMSCHED_STATS_EN
  logic [15:0] st_iss_q, st_iss_d, st_rnd_q, st_rnd_d, st_bp_q, st_bp_d;
  always_comb begin
    st_iss_d = st_iss_q + 16'(issue && st_iss_q != '1);
    st_rnd_d = st_rnd_q + 16'(state_q == RUN && |req_valid && !rnd_valid && st_rnd_q != '1);
    st_bp_d = st_bp_q + 16'(s2_v_q && !out_ready && st_bp_q != '1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_iss_q <= '0;
      st_rnd_q <= '0;
      st_bp_q <= '0;
    end else begin
      st_iss_q <= st_iss_d;
      st_rnd_q <= st_rnd_d;
      st_bp_q <= st_bp_d;
    end
  end
  assign stat_issued = st_iss_q;
  assign stat_rnd_stall = st_rnd_q;
  assign stat_bp_stall = st_bp_q;
`endif
endmodule

// File: tb/tb_dom_mult_sched.sv
// tb_dom_mult_sched: directed and randomized checks of the shared DOM GF(2^2) multiplier scheduler.
module tb_dom_mult_sched;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req_valid = '0, req_ready;
  logic [7:0] req_ax = '0, req_ay = '0, req_bx = '0, req_by = '0;
  logic rnd_valid = 1'b0, rnd_ready, out_valid, out_ready = 1'b0, flush = 1'b0, flush_done, busy;
  logic [1:0] rnd_z = '0, out_id, out_aq, out_bq;
  int n_cmp = 0, n_bad = 0;
  dom_mult_sched #(.NREQ(4), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_ax(req_ax), .req_ay(req_ay), .req_bx(req_bx), .req_by(req_by),
    .rnd_valid(rnd_valid), .rnd_z(rnd_z), .rnd_ready(rnd_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_aq(out_aq), .out_bq(out_bq), .flush(flush), .flush_done(flush_done), .busy(busy)
  );
  always #5 clk = ~clk;
  // Carry-less multiply then reduce by x^2+x+1.
  function automatic logic [1:0] gf_ref(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] p = '0;
    for (int i = 0; i < 2; i++) if (b[i]) p = p ^ ({1'b0, a} << i);
    if (p[2]) p = p ^ 3'b111;
    return p[1:0];
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask
  task automatic set_op(input int i, input logic [1:0] ax, ay, bx, by);
    req_ax[2*i +: 2] = ax;
    req_ay[2*i +: 2] = ay;
    req_bx[2*i +: 2] = bx;
    req_by[2*i +: 2] = by;
  endtask
  int exp_seq[7] = '{0, 1, 2, 3, 0, 2, 3};
  int qid[$];
  logic [1:0] qv[$];
  int issued, g, e_id, cycles;
  logic [1:0] e_v;
  initial begin
    cyc();
    cyc();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rnd_ready", rnd_ready, 0);
    chk("rst_out_data", {out_id, out_aq, out_bq}, 0);
    chk("rst_flush_done", flush_done, 0);
    rst = 1'b0;
    req_valid = 4'b0001;
    set_op(0, 2'd2, 2'd3, 2'd0, 2'd0);
    rnd_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("t1_req_ready", req_ready, 4'b0001);
    chk("t1_rnd_ready", rnd_ready, 1);
    cyc();
    req_valid = '0;
    #1;
    chk("t1_busy", busy, 1);
    chk("t1_early_valid", out_valid, 0);
    cyc();
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_id", out_id, 0);
    chk("t1_out_aq", out_aq, 1);
    chk("t1_out_bq", out_bq, 0);
    cyc();
    chk("t1_after", out_valid, 0);
    // Round-robin with all requesters valid, dropping requester 1 from the 5th cycle.
    do_reset();
    for (int c = 0; c < 7; c++) begin
      req_valid = (c >= 4) ? 4'b1101 : 4'b1111;
      #1;
      chk($sformatf("rr_grant%0d", c), req_ready, 32'd1 << exp_seq[c]);
      cyc();
    end
    req_valid = '0;
    // Randomness stall holds the pointer.
    do_reset();
    req_valid = 4'b1111;
    #1;
    chk("rnd_g0", req_ready, 4'b0001);
    cyc();
    rnd_valid = 1'b0;
    #1;
    chk("rnd_stall_ready", req_ready, 0);
    chk("rnd_stall_rnd", rnd_ready, 0);
    cyc();
    rnd_valid = 1'b1;
    #1;
    chk("rnd_g1", req_ready, 4'b0010);
    cyc();
    req_valid = '0;
    // Backpressure with two ops in flight.
    do_reset();
    out_ready = 1'b0;
    req_valid = 4'b0001;
    set_op(0, 2'd1, 2'd1, 2'd0, 2'd0);
    set_op(1, 2'd2, 2'd2, 2'd0, 2'd0);
    rnd_z = 2'd0;
    #1;
    chk("bp_g0", req_ready, 4'b0001);
    cyc();
    req_valid = 4'b0010;
    #1;
    chk("bp_g1", req_ready, 4'b0010);
    cyc();
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp_nogrant%0d", c), req_ready, 0);
      chk($sformatf("bp_hold%0d", c), {out_valid, out_id, out_aq, out_bq}, {1'b1, 2'd0, 2'd1, 2'd0});
      cyc();
    end
    req_valid = '0;
    out_ready = 1'b1;
    #1;
    chk("bp_rel0", {out_valid, out_id, out_aq}, {1'b1, 2'd0, 2'd1});
    cyc();
    chk("bp_rel1", {out_valid, out_id, out_aq, out_bq}, {1'b1, 2'd1, 2'd3, 2'd0});
    cyc();
    chk("bp_empty", out_valid, 0);
    // Flush with two ops in flight, then reset in the middle of a drain.
    do_reset();
    req_valid = 4'b0001;
    #1;
    chk("fl_g0", req_ready, 4'b0001);
    cyc();
    req_valid = 4'b0010;
    #1;
    chk("fl_g1", req_ready, 4'b0010);
    cyc();
    flush = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("fl_nogrant0", req_ready, 0);
    chk("fl_beat0", {out_valid, out_id}, {1'b1, 2'd0});
    cyc();
    flush = 1'b0;
    #1;
    chk("fl_nogrant1", req_ready, 0);
    chk("fl_beat1", {out_valid, out_id, flush_done}, {1'b1, 2'd1, 1'b0});
    cyc();
    chk("fl_done", flush_done, 1);
    chk("fl_busy", busy, 0);
    chk("fl_nogrant2", {req_ready, out_valid}, 0);
    cyc();
    chk("fl_done_once", flush_done, 0);
    chk("fl_resume", req_ready, 4'b0100);
    cyc();
    flush = 1'b1;
    req_valid = '0;
    cyc();
    flush = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("rst_drain_outs", {out_valid, out_id, out_aq, out_bq, flush_done, busy, req_ready, rnd_ready}, 0);
    // Randomized shares and Z, scoreboard of grant order.
    do_reset();
    issued = 0;
    cycles = 0;
    while ((issued < 1000 || qid.size() > 0) && cycles < 8000) begin
      req_valid = (issued < 1000) ? 4'($urandom) : 4'd0;
      req_ax = 8'($urandom);
      req_ay = 8'($urandom);
      req_bx = 8'($urandom);
      req_by = 8'($urandom);
      rnd_z = 2'($urandom);
      rnd_valid = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (qid.size() == 0) chk("rand_spurious", out_valid, 0);
        else begin
          e_id = qid.pop_front();
          e_v = qv.pop_front();
          chk("rand_id", out_id, e_id);
          chk("rand_prod", out_aq ^ out_bq, e_v);
        end
      end
      chk("rand_onehot", $onehot0(req_ready), 1);
      if (rnd_ready) begin
        g = 0;
        for (int i = 0; i < 4; i++) if (req_ready[i]) g = i;
        qid.push_back(g);
        qv.push_back(gf_ref(req_ax[2*g +: 2] ^ req_bx[2*g +: 2], req_ay[2*g +: 2] ^ req_by[2*g +: 2]));
        issued++;
      end
      cycles++;
      cyc();
    end
    chk("rand_issued", issued, 1000);
    chk("rand_drained", qid.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
